// File: rtl/inst_fetcher_pkg.sv
// Shared fetch-stage definitions: widths, boolean constants, RV32 opcodes,
// instruction-queue default depth and the fetch FSM state encoding.
package inst_fetcher_pkg;

    localparam int ADDR_WIDTH       = 32;
    localparam int INST_WIDTH       = 32;
    localparam int IQ_DEPTH_DEFAULT = 16;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_WAIT = 2'd1,
        IF_DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/inst_fetcher_queue.sv
// Circular instruction queue holding {inst, pc, pred_jump}; clear has priority
// over push/pop, and rdy=0 (en) freezes all state.
module inst_queue #(
    parameter int DEPTH  = 16,
    parameter int INST_W = 32,
    parameter int ADDR_W = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clear,
    input  logic              push,
    input  logic [INST_W-1:0] push_inst,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic              push_jump,
    input  logic              pop,
    output logic [INST_W-1:0] head_inst,
    output logic [ADDR_W-1:0] head_pc,
    output logic              head_jump,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic              jump_mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    assign head_inst = inst_mem[head];
    assign head_pc   = pc_mem[head];
    assign head_jump = jump_mem[head];

    // Payload storage carries no reset; only pointers and count are control.
    always_ff @(posedge clk) begin
        if (en && do_push) begin
            inst_mem[tail] <= push_inst;
            pc_mem[tail]   <= push_pc;
            jump_mem[tail] <= push_jump;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (en) begin
            if (clear) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (do_push) tail <= tail + PTR_W'(1);
                if (do_pop)  head <= head + PTR_W'(1);
                case ({do_push, do_pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: rtl/inst_fetcher.sv
// Fetch stage: PC register, single-outstanding ICache request FSM, predictor
// steering and the instruction queue toward the decoder.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int               IQ_DEPTH = IQ_DEPTH_DEFAULT,
    parameter int               ADDR_W   = ADDR_WIDTH,
    parameter int               INST_W   = INST_WIDTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    output logic                     IC_req_valid,
    output logic [ADDR_W-1:0]        IC_req_addr,
    input  logic                     IC_resp_valid,
    input  logic [INST_W-1:0]        IC_resp_inst,
    output logic [INST_W-1:0]        PDC_inst,
    output logic [ADDR_W-1:0]        PDC_inst_pc,
    input  logic                     PDC_need_jump,
    input  logic signed [ADDR_W-1:0] PDC_predicted_imm,
    output logic                     DEC_valid,
    output logic [INST_W-1:0]        DEC_inst,
    output logic [ADDR_W-1:0]        DEC_pc,
    output logic                     DEC_pred_jump,
    input  logic                     DEC_ready,
    input  logic                     ROB_flush,
    input  logic [ADDR_W-1:0]        ROB_target_pc
);

    localparam int CNT_W = $clog2(IQ_DEPTH) + 1;

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc_reg;
    logic [CNT_W-1:0]  iq_count;
    logic              iq_full;
    logic              iq_empty;
    logic              push;
    logic              pop;

    function automatic logic [ADDR_W-1:0] next_pc(
        input logic [ADDR_W-1:0]        pc,
        input logic                     jump,
        input logic signed [ADDR_W-1:0] imm
    );
        return jump ? pc + $unsigned(imm) : pc + ADDR_W'(4);
    endfunction

    assign IC_req_valid = (state == IF_WAIT);
    assign IC_req_addr  = pc_reg;
    assign PDC_inst     = IC_resp_inst;
    assign PDC_inst_pc  = pc_reg;
    assign DEC_valid    = !iq_empty;

    assign push = (state == IF_WAIT) && IC_resp_valid && !ROB_flush && !iq_full;
    assign pop  = DEC_ready && !ROB_flush;

    always_comb begin
        state_next = state;
        unique case (state)
            IF_IDLE: begin
                if (!ROB_flush && (iq_count < CNT_W'(IQ_DEPTH))) state_next = IF_WAIT;
            end
            IF_WAIT: begin
                if (IC_resp_valid)  state_next = IF_IDLE;
                else if (ROB_flush) state_next = IF_DROP;
            end
            // The stale response is the only way out; a flush here just retargets pc.
            IF_DROP: begin
                if (IC_resp_valid) state_next = IF_IDLE;
            end
            default: state_next = IF_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IF_IDLE;
            pc_reg <= RESET_PC;
        end else if (rdy) begin
            state <= state_next;
            if (ROB_flush)
                pc_reg <= ROB_target_pc;
            else if (push)
                pc_reg <= next_pc(pc_reg, PDC_need_jump, PDC_predicted_imm);
        end
    end

    inst_queue #(
        .DEPTH  (IQ_DEPTH),
        .INST_W (INST_W),
        .ADDR_W (ADDR_W)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .en        (rdy),
        .clear     (ROB_flush),
        .push      (push),
        .push_inst (IC_resp_inst),
        .push_pc   (pc_reg),
        .push_jump (PDC_need_jump),
        .pop       (pop),
        .head_inst (DEC_inst),
        .head_pc   (DEC_pc),
        .head_jump (DEC_pred_jump),
        .full      (iq_full),
        .empty     (iq_empty),
        .count     (iq_count)
    );

endmodule
